// File: rtl/chrono_ctrl_pkg.sv
// Shared definitions for the chronometer button sequencer.
// Holds the FSM state encodings and the event-priority rules used by the stopwatch top level.
package chrono_ctrl_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4,
        ST_CLR   = 3'd5
    } chrono_state_e;

    // Event priority: clear > limit reached > start/stop; a lap in RUN is captured
    // alongside any transition except clear.
    function automatic logic drivesStart(chrono_state_e s);
        return (s == ST_ARM) || (s == ST_CLR);
    endfunction

endpackage

// File: rtl/chrono_ctrl_btn_event.sv
// Button conditioning: 2-FF synchroniser followed by a rising-edge detector.
// A held button yields a single one-cycle event.
module btn_event (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic event_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign event_o = sync2_q & ~prev_q;

endmodule

// File: rtl/chrono_ctrl.sv
// Button-driven sequencer for the chronometer: turns start/stop, lap and clear
// buttons into chronometer start/enable controls, captures laps and stops at the limit.
module chrono_ctrl
    import chrono_ctrl_pkg::*;
#(
    parameter int LIMIT_CNT = 1000,
    parameter int TIMER_W   = $clog2(LIMIT_CNT),
    parameter int LAP_W     = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               btn_start_stop,
    input  logic               btn_lap,
    input  logic               btn_clear,
    input  logic [TIMER_W-1:0] timer,
    output logic               chrono_start,
    output logic               chrono_enable,
    output logic [TIMER_W-1:0] lap_time,
    output logic               lap_valid,
    output logic [LAP_W-1:0]   lap_count,
    output logic               running,
    output logic               done,
    output logic [STATE_W-1:0] state
);

    logic evSs;
    logic evLap;
    logic evClr;

    btn_event uSsEvent  (.clk(clk), .rst_n(rst_n), .btn_i(btn_start_stop), .event_o(evSs));
    btn_event uLapEvent (.clk(clk), .rst_n(rst_n), .btn_i(btn_lap),        .event_o(evLap));
    btn_event uClrEvent (.clk(clk), .rst_n(rst_n), .btn_i(btn_clear),      .event_o(evClr));

    chrono_state_e     state_q, state_d;
    logic              chronoStart_q;
    logic              chronoEnable_q;
    logic              running_q;
    logic              done_q;
    logic [TIMER_W-1:0] lapTime_q;
    logic              lapValid_q;
    logic [LAP_W-1:0]  lapCount_q;

    logic atLimit;
    logic lapTake;

    assign atLimit = (timer == TIMER_W'(LIMIT_CNT - 1));
    assign lapTake = evLap && !evClr && (state_q == ST_RUN);

    always_comb begin
        state_d = state_q;
        if (evClr) begin
            state_d = ST_CLR;
        end else begin
            unique case (state_q)
                ST_IDLE:  if (evSs) state_d = ST_ARM;
                ST_ARM:   state_d = ST_RUN;
                ST_RUN: begin
                    if (atLimit)   state_d = ST_DONE;
                    else if (evSs) state_d = ST_PAUSE;
                end
                ST_PAUSE: if (evSs) state_d = ST_RUN;
                ST_DONE:  state_d = ST_DONE;
                ST_CLR:   state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            chronoStart_q  <= 1'b0;
            chronoEnable_q <= 1'b0;
            running_q      <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            chronoStart_q  <= drivesStart(state_d);
            chronoEnable_q <= (state_d == ST_RUN);
            running_q      <= (state_d == ST_RUN);
            done_q         <= (state_d == ST_DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lapTime_q  <= '0;
            lapValid_q <= 1'b0;
            lapCount_q <= '0;
        end else if (state_d == ST_CLR) begin
            lapTime_q  <= '0;
            lapValid_q <= 1'b0;
            lapCount_q <= '0;
        end else if (lapTake) begin
            lapTime_q  <= timer;
            lapValid_q <= 1'b1;
            lapCount_q <= lapCount_q + 1'b1;
        end else begin
            lapValid_q <= 1'b0;
        end
    end

    assign chrono_start  = chronoStart_q;
    assign chrono_enable = chronoEnable_q;
    assign running       = running_q;
    assign done          = done_q;
    assign lap_time      = lapTime_q;
    assign lap_valid     = lapValid_q;
    assign lap_count     = lapCount_q;
    assign state         = state_q;

endmodule

// File: tb/tb_chrono_ctrl.sv
// Testbench for chrono_ctrl with a saturating chronometer model and a lap scoreboard.
// Expected laps are queued when the lap button is pressed and popped on lap_valid.
module tb_chrono_ctrl;

    localparam int LIMIT = 16;
    localparam int TW    = 4;
    localparam int LW    = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          btn_start_stop = 1'b0;
    logic          btn_lap = 1'b0;
    logic          btn_clear = 1'b0;
    logic [TW-1:0] timer;
    logic          chrono_start;
    logic          chrono_enable;
    logic [TW-1:0] lap_time;
    logic          lap_valid;
    logic [LW-1:0] lap_count;
    logic          running;
    logic          done;
    logic [2:0]    state;

    typedef struct {
        logic [TW-1:0] t;
        logic [LW-1:0] c;
    } lapExp_t;

    lapExp_t lapQ[$];
    int compared   = 0;
    int mismatched = 0;

    chrono_ctrl #(.LIMIT_CNT(LIMIT), .LAP_W(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .btn_start_stop(btn_start_stop), .btn_lap(btn_lap), .btn_clear(btn_clear),
        .timer(timer),
        .chrono_start(chrono_start), .chrono_enable(chrono_enable),
        .lap_time(lap_time), .lap_valid(lap_valid), .lap_count(lap_count),
        .running(running), .done(done), .state(state)
    );

    always #5 clk = ~clk;

    // Chronometer model: cleared by start, counts while enabled, stops at the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                    timer <= '0;
        else if (chrono_start)                         timer <= '0;
        else if (chrono_enable && timer != TW'(LIMIT-1)) timer <= timer + 1'b1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic waitTimer(input logic [TW-1:0] v, input string tag);
        int n = 0;
        while (timer !== v && n < 64) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, 32'(timer), 32'(v));
    endtask

    task automatic pushLap(input logic [TW-1:0] t, input logic [LW-1:0] c);
        lapExp_t e;
        e.t = t;
        e.c = c;
        lapQ.push_back(e);
    endtask

    // Scoreboard monitor: every lap_valid cycle must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && lap_valid) begin
            if (lapQ.size() == 0) begin
                checkOutput("lap_unexpected", 32'(lap_valid), 32'd0);
            end else begin
                lapExp_t e;
                e = lapQ.pop_front();
                checkOutput("lap_time", 32'(lap_time), 32'(e.t));
                checkOutput("lap_count", 32'(lap_count), 32'(e.c));
            end
        end
    end

    initial begin
        // Reset state
        @(negedge clk);
        checkOutput("rst_state", 32'(state), 32'd0);
        checkOutput("rst_enable", 32'(chrono_enable), 32'd0);
        checkOutput("rst_start", 32'(chrono_start), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: start from IDLE
        btn_start_stop = 1'b1;
        @(negedge clk);
        checkOutput("t1_start_E0", 32'(chrono_start), 32'd0);
        @(negedge clk);
        checkOutput("t1_state_E1", 32'(state), 32'd0);
        @(negedge clk);
        checkOutput("t1_start_E2", 32'(chrono_start), 32'd1);
        checkOutput("t1_arm_E2", 32'(state), 32'd1);
        @(negedge clk);
        checkOutput("t1_start_E3", 32'(chrono_start), 32'd0);
        checkOutput("t1_enable_E3", 32'(chrono_enable), 32'd1);
        checkOutput("t1_running_E3", 32'(running), 32'd1);
        btn_start_stop = 1'b0;

        // 2: lap sampled on the cycle timer=5, button held
        waitTimer(4'd3, "t2_wait3");
        btn_lap = 1'b1;
        pushLap(4'd5, 4'd1);
        repeat (5) @(negedge clk);
        btn_lap = 1'b0;
        checkOutput("t2_lapq_empty", 32'(lapQ.size()), 32'd0);
        checkOutput("t2_lap_count", 32'(lap_count), 32'd1);

        // 3: pause then resume without a restart
        waitTimer(4'd8, "t3_wait8");
        btn_start_stop = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("t3_pause", 32'(state), 32'd3);
        checkOutput("t3_pause_en", 32'(chrono_enable), 32'd0);
        btn_start_stop = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("t3_hold", 32'(timer), 32'd11);
        btn_start_stop = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("t3_no_restart", 32'(chrono_start), 32'd0);
        end
        checkOutput("t3_resume", 32'(state), 32'd2);
        btn_start_stop = 1'b0;
        @(negedge clk);
        checkOutput("t3_timer_cont", 32'(timer), 32'd12);

        // 4: lap just before the limit, then DONE ignores start/stop and lap
        btn_lap = 1'b1;
        pushLap(4'd14, 4'd2);
        repeat (4) @(negedge clk);
        btn_lap = 1'b0;
        checkOutput("t4_done_state", 32'(state), 32'd4);
        checkOutput("t4_done", 32'(done), 32'd1);
        checkOutput("t4_done_en", 32'(chrono_enable), 32'd0);
        checkOutput("t4_timer", 32'(timer), 32'd15);
        repeat (3) @(negedge clk);
        btn_start_stop = 1'b1;
        btn_lap = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("t4_ignore_state", 32'(state), 32'd4);
        checkOutput("t4_ignore_laps", 32'(lap_count), 32'd2);
        btn_start_stop = 1'b0;
        btn_lap = 1'b0;
        repeat (3) @(negedge clk);
        btn_clear = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("t4_clr_state", 32'(state), 32'd5);
        checkOutput("t4_clr_start", 32'(chrono_start), 32'd1);
        checkOutput("t4_clr_count", 32'(lap_count), 32'd0);
        @(negedge clk);
        checkOutput("t4_idle", 32'(state), 32'd0);
        btn_clear = 1'b0;
        repeat (3) @(negedge clk);

        // 5: clear and lap together in RUN
        btn_start_stop = 1'b1;
        repeat (4) @(negedge clk);
        btn_start_stop = 1'b0;
        waitTimer(4'd2, "t5_wait2");
        btn_lap = 1'b1;
        pushLap(4'd4, 4'd1);
        repeat (4) @(negedge clk);
        btn_lap = 1'b0;
        repeat (3) @(negedge clk);
        btn_lap = 1'b1;
        btn_clear = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("t5_clr_state", 32'(state), 32'd5);
        checkOutput("t5_lap_time", 32'(lap_time), 32'd0);
        checkOutput("t5_lap_count", 32'(lap_count), 32'd0);
        btn_lap = 1'b0;
        btn_clear = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("t5_idle", 32'(state), 32'd0);

        // 6: asynchronous reset in the middle of RUN
        btn_start_stop = 1'b1;
        repeat (4) @(negedge clk);
        btn_start_stop = 1'b0;
        waitTimer(4'd2, "t6_wait2");
        btn_lap = 1'b1;
        pushLap(4'd4, 4'd1);
        repeat (4) @(negedge clk);
        btn_lap = 1'b0;
        waitTimer(4'd9, "t6_wait9");
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_state", 32'(state), 32'd0);
        checkOutput("t6_rst_enable", 32'(chrono_enable), 32'd0);
        checkOutput("t6_rst_running", 32'(running), 32'd0);
        checkOutput("t6_rst_count", 32'(lap_count), 32'd0);
        checkOutput("t6_rst_laptime", 32'(lap_time), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("t6_idle", 32'(state), 32'd0);
        checkOutput("t6_idle_en", 32'(chrono_enable), 32'd0);

        checkOutput("lap_queue_drained", 32'(lapQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
